mem_dump_engine: RTL and testbench
==================================

# mem_dump_engine

Bulk read-out engine that streams one complete 256-word EBR block to the UART transmitter. It sits beside the UART controller and drives the `bram` instance's read port (`mem_select`, address, `rd_en`). It captures each 16-bit `data_out` word and serialises it as two bytes into the UART TX byte interface with a valid/ready handshake. This replaces 256 individual host read commands with one dump command.

## Interface
- Parameters:
  - `MEM_SELECT_BITS`, default 5: width of the block select; matches `$clog2(NUM_BLOCKS)`.
  - `WORDS`, default 256: words per block. Must be a power of two, at most 256.
- Ports:
  - `clk` input 1: system clock.
  - `resetn` input 1: asynchronous, active-low reset.
  - `start` input 1: single-cycle dump request; honoured only in IDLE.
  - `block_sel` input MEM_SELECT_BITS: EBR to dump; latched on an accepted `start`.
  - `mem_select` output MEM_SELECT_BITS: block select to BRAM.
  - `mem_addr` output 8: word address to BRAM.
  - `rd_en` output 1: BRAM read strobe.
  - `mem_out` input 16: BRAM read data, valid the cycle after `rd_en`.
  - `tx_data` output 8: byte to the UART TX.
  - `tx_valid` output 1: `tx_data` is valid.
  - `tx_ready` input 1: UART TX can accept a byte this cycle.
  - `busy` output 1: high from an accepted `start` until `done`.
  - `done` output 1: one-cycle pulse after the last byte is accepted.

## Operation
- State machine: IDLE → READ → CAPTURE → SEND_HI → SEND_LO → (READ | CSUM_HI) → … → FINISH → IDLE.
- IDLE:
  - When `start`=1, latch `block_sel` into `mem_select`, clear the address counter and checksum, set `busy`, and go to READ.
- READ: assert `rd_en`=1 for exactly one cycle, with `mem_addr` set to the counter. Go to CAPTURE.
- CAPTURE: register `mem_out` into the word register and add it to the checksum (16-bit, modulo 2^16, carries discarded). Go to SEND_HI.
- SEND_HI:
  - `tx_valid`=1 and `tx_data`=word[15:8].
  - On `tx_valid`&&`tx_ready`, go to SEND_LO.
- SEND_LO:
  - `tx_data`=word[7:0].
  - On handshake with counter = WORDS-1, go to CSUM_HI if the checksum is compiled in, otherwise to FINISH.
  - On handshake otherwise, increment the counter and go to READ.
- CSUM_HI / CSUM_LO: send checksum[15:8], then checksum[7:0], using the same handshake as SEND_HI/SEND_LO.
- FINISH: `done`=1 for one cycle and `busy`=0 on the next cycle. Go to IDLE.
- Byte order is always high byte first. Words are sent in ascending address order, 0 to WORDS-1.
- `start` is ignored while `busy`=1.
- `block_sel` changes after acceptance do not affect a dump in progress.
- `rd_en` is never asserted outside READ. `mem_select` and `mem_addr` hold their last values in IDLE.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `rd_en`=0, `mem_addr`=0, `mem_select`=0, `busy`=0, `done`=0. State = IDLE, counter = 0, checksum = 0.
- Reset is asynchronous. Asserting `resetn` mid-dump aborts immediately:
  - No `done` pulse is generated.
  - The next dump restarts at word 0.
- `start` sampled in cycle N gives `busy`=1 and READ in cycle N+1, and `rd_en` in cycle N+1.
- First `tx_valid` is in cycle N+3.
- Handshake rules:
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and state hold, and `tx_valid` never drops.
  - `tx_valid` rises without waiting for `tx_ready`. `tx_ready` may be high continuously.
- With `tx_ready` held at 1, each word takes 4 cycles (READ, CAPTURE, HI, LO). A full dump takes 4·WORDS + 2 cycles, plus 2 with the checksum.
- The counter is log2(WORDS) bits wide, zero-extended onto `mem_addr`. The last-word test uses an explicit compare, never wrap detection.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - Accumulate the 16-bit sum and append 2 checksum bytes after the data.
  - Total bytes sent = 2·WORDS + 2.
- `DUMP_CHECKSUM_EN` undefined:
  - The CSUM states and the accumulator are not synthesised.
  - Total bytes sent = 2·WORDS; SEND_LO on the last word goes straight to FINISH.

## Test plan
- BRAM model filled with word[i] = 16'hA500+i, `block_sel`=3, `tx_ready`=1 → `mem_select`=3 throughout. 512 bytes are seen: A5,00,A5,01,…,A5,FF, then `done` pulses exactly once.
- Same fill with `DUMP_CHECKSUM_EN` defined → 514 bytes. The last two bytes are the sum of A500..A5FF mod 2^16 = 16'h7F80, sent as 7F, 80.
- `tx_ready` toggled randomly (including stretches of 20 cycles low) → no byte is lost or duplicated, `tx_data` is stable whenever `tx_valid`=1 and `tx_ready`=0, and the byte stream is identical to the previous case.
- Second `start` pulsed, with a different `block_sel`, mid-dump → ignored. The dump completes on the original block, and `busy` stays 1 until `done`.
- `resetn` asserted after byte 100 → all outputs return to their reset values asynchronously, with no `done`. A new `start` then dumps from word 0.
- `tx_ready`=1 with `start` in cycle 0 → `rd_en` is high in cycles 1, 5, 9, …, the first `tx_valid` is in cycle 3, and `rd_en` is never high while `tx_valid`=1.

Source files
------------

// File: rtl/mem_dump_engine.sv
// mem_dump_engine: streams one EBR block word by word to the UART TX byte interface, high byte first.
// Optional feature macro DUMP_CHECKSUM_EN appends the 16-bit modulo sum of all words, high byte first.
module mem_dump_engine #(
  parameter int unsigned MEM_SELECT_BITS = 5,
  parameter int unsigned WORDS           = 256
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [MEM_SELECT_BITS-1:0] block_sel,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [7:0]                 mem_addr,
  output logic                       rd_en,
  input  logic [15:0]                mem_out,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND_HI,
    SEND_LO,
`ifdef DUMP_CHECKSUM_EN
    CSUM_HI,
    CSUM_LO,
`endif
    FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       word_lo;
`ifdef DUMP_CHECKSUM_EN
  logic [15:0]      csum;
`endif

  // Only the low byte needs storing: the high byte goes straight from mem_out to tx_data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      word_lo    <= '0;
      mem_select <= '0;
      mem_addr   <= '0;
      rd_en      <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_select <= block_sel;
            cnt        <= '0;
            mem_addr   <= '0;
            rd_en      <= 1'b1;
            busy       <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            csum       <= '0;
`endif
            state      <= READ;
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          word_lo  <= mem_out[7:0];
`ifdef DUMP_CHECKSUM_EN
          csum     <= csum + mem_out;
`endif
          tx_data  <= mem_out[15:8];
          tx_valid <= 1'b1;
          state    <= SEND_HI;
        end
        SEND_HI: begin
          if (tx_ready) begin
            tx_data <= word_lo;
            state   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_ready) begin
            if (cnt == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
              tx_data  <= csum[15:8];
              state    <= CSUM_HI;
`else
              tx_valid <= 1'b0;
              done     <= 1'b1;
              state    <= FINISH;
`endif
            end else begin
              cnt      <= cnt + CNT_W'(1);
              mem_addr <= 8'(cnt + CNT_W'(1));
              rd_en    <= 1'b1;
              tx_valid <= 1'b0;
              state    <= READ;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM_HI: begin
          if (tx_ready) begin
            tx_data <= csum[7:0];
            state   <= CSUM_LO;
          end
        end
        CSUM_LO: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= FINISH;
          end
        end
`endif
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Scoreboard bench for mem_dump_engine: expected bytes are queued at start, a monitor pops them on each TX handshake.
module tb_mem_dump_engine;

  localparam int unsigned SB = 5;
  localparam int unsigned W  = 256;
`ifdef DUMP_CHECKSUM_EN
  localparam int unsigned EXTRA = 2;
`else
  localparam int unsigned EXTRA = 0;
`endif
  localparam int unsigned NBYTES   = 2 * W + EXTRA;
  localparam int unsigned DONE_CYC = 4 * W + 1 + EXTRA;

  logic          clk = 1'b0;
  logic          resetn, start, rd_en, tx_valid, busy, done;
  logic          tx_ready = 1'b1;
  logic [SB-1:0] block_sel, mem_select;
  logic [7:0]    mem_addr, tx_data;
  logic [15:0]   mem_out;

  int vectors = 0, errors = 0;
  int done_cnt = 0, bytes_seen = 0;
  int rdy_mode = 0, stall_left = 0;
  byte unsigned  exp_q[$];
  logic [SB-1:0] exp_blk = '0;
  logic          held_v = 1'b0;
  logic [7:0]    held_d = '0;

  always #5 clk = ~clk;

  mem_dump_engine #(.MEM_SELECT_BITS(SB), .WORDS(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .block_sel(block_sel),
    .mem_select(mem_select), .mem_addr(mem_addr), .rd_en(rd_en), .mem_out(mem_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  // Block 3 holds A500+i; other blocks differ in the high byte so a wrong select shows up.
  function automatic logic [15:0] mem_word(input logic [SB-1:0] b, input logic [7:0] a);
    logic [7:0] hi;
    hi = 8'hA5 ^ 8'(b ^ SB'(3));
    return {hi, a};
  endfunction

  always @(posedge clk) if (rd_en) mem_out <= mem_word(mem_select, mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // tx_ready changes just after each rising edge; mode 1 mixes random toggling with 20-cycle stalls.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) tx_ready = 1'b1;
    else if (stall_left > 0) begin tx_ready = 1'b0; stall_left--; end
    else if ($urandom_range(0, 15) == 0) begin tx_ready = 1'b0; stall_left = 19; end
    else tx_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!resetn) held_v = 1'b0;
    else begin
      if (held_v) begin
        check("hold_valid", tx_valid, 1'b1);
        check("hold_data", tx_data, held_d);
      end
      if (tx_valid && tx_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %0h expected none", tx_data);
        end else begin
          byte unsigned e;
          e = exp_q.pop_front();
          vectors--;
          check("byte", tx_data, e);
        end
        bytes_seen++;
      end
      if (rd_en) check("rd_en_while_tx_valid", tx_valid, 1'b0);
      if (busy) check("mem_select", mem_select, exp_blk);
      if (done) done_cnt++;
      held_v = tx_valid && !tx_ready;
      held_d = tx_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_dump(input logic [SB-1:0] b);
    logic [15:0] sum, w;
    sum = '0;
    for (int i = 0; i < int'(W); i++) begin
      w = mem_word(b, 8'(i));
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      sum = sum + w;
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(sum[15:8]);
    exp_q.push_back(sum[7:0]);
`else
    sum = '0;
`endif
  endtask

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic issue_start(input logic [SB-1:0] b);
    start = 1'b1; block_sel = b; exp_blk = b;
    push_dump(b);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (done) begin cycles = i; break; end
    end
    if (cycles < 0) begin
      vectors++; errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic check_idle_after(input string tag, input int exp_done, input int exp_bytes);
    step();
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_done_count"}, done_cnt, exp_done);
    check({tag, "_byte_count"}, bytes_seen, exp_bytes);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 8'h00);
    check({tag, "_mem_select"}, mem_select, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, dc;
    resetn = 1'b0; start = 1'b0; block_sel = '0;
    #1;
    check_reset_outputs("reset");
    step(); step();
    resetn = 1'b1;
    step();

    // Cycle-exact start with tx_ready held high, block 3.
    rdy_mode = 0;
    issue_start(SB'(3));
    check("c1_rd_en", rd_en, 1'b1);
    check("c1_busy", busy, 1'b1);
    check("c1_tx_valid", tx_valid, 1'b0);
    check("c1_mem_addr", mem_addr, 8'h00);
    step();
    check("c2_rd_en", rd_en, 1'b0);
    check("c2_tx_valid", tx_valid, 1'b0);
    step();
    check("c3_tx_valid", tx_valid, 1'b1);
    check("c3_tx_data", tx_data, 8'hA5);
    step();
    check("c4_tx_data", tx_data, 8'h00);
    step();
    check("c5_rd_en", rd_en, 1'b1);
    check("c5_mem_addr", mem_addr, 8'h01);
    wait_done(20000, n);
    check("done_cycle", 5 + n, DONE_CYC);
    check_idle_after("a", 1, NBYTES);
    check("a_mem_select_hold", mem_select, SB'(3));

    // Random back-pressure plus an ignored second start with another block.
    rdy_mode = 1;
    issue_start(SB'(3));
    repeat (300) step();
    start = 1'b1; block_sel = SB'(7);
    step();
    start = 1'b0;
    check("b_busy_after_2nd_start", busy, 1'b1);
    check("b_mem_select_kept", mem_select, SB'(3));
    wait_done(40000, n);
    check_idle_after("b", 2, 2 * NBYTES);

    // Different block, ready held high.
    rdy_mode = 0;
    issue_start(SB'(9));
    wait_done(20000, n);
    check_idle_after("c", 3, 3 * NBYTES);

    // Abort with async reset after byte 100, then restart from word 0.
    rdy_mode = 1;
    base = bytes_seen;
    dc = done_cnt;
    issue_start(SB'(3));
    n = 0;
    while (bytes_seen < base + 100 && n < 10000) begin step(); n++; end
    check("d_reached_100_bytes", bytes_seen >= base + 100, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    step(); step();
    check("d_no_done", done_cnt, dc);
    resetn = 1'b1;
    step();
    rdy_mode = 0;
    base = bytes_seen;
    issue_start(SB'(3));
    check("d_restart_addr", mem_addr, 8'h00);
    wait_done(20000, n);
    check_idle_after("d", dc + 1, base + NBYTES);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
